// File: rtl/alu_div_seq.sv
// Multi-cycle unsigned restoring divider for the Execute stage.
// Holds the pipeline via o_Stall while running and flags divide-by-zero for condition codes.
module alu_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_Start,
    input  logic             i_Flush,
    input  logic [WIDTH-1:0] i_Op1,
    input  logic [WIDTH-1:0] i_Op2,
    output logic             o_Busy,
    output logic             o_Stall,
    output logic             o_Done,
    output logic [WIDTH-1:0] ro_Quotient,
    output logic [WIDTH-1:0] ro_Remainder,
    output logic             ro_DivZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] res_quo_q, res_quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             divzero_q, divzero_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             accept_s;
    logic             last_s;
    logic [WIDTH:0]   step_t;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] step_quo;

    assign accept_s = (state_q == S_IDLE) && i_Start && !i_Flush;
    assign last_s   = (count_q == LAST_STEP);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            count_q   <= '0;
            res_quo_q <= '0;
            res_rem_q <= '0;
            divzero_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            count_q   <= count_d;
            res_quo_q <= res_quo_d;
            res_rem_q <= res_rem_d;
            divzero_q <= divzero_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; a flush returns to IDLE from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = (i_Op2 == '0) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_Flush) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // One restoring step. The trial value is WIDTH+1 bits so the compare cannot overflow;
    // a successful subtract always fits back in WIDTH bits because rem < div.
    always_comb begin
        step_t = {rem_q, quo_q[WIDTH-1]};
        if (step_t >= {1'b0, div_q}) begin
            step_rem  = step_t[WIDTH-1:0] - div_q;
            step_qbit = 1'b1;
        end else begin
            step_rem  = step_t[WIDTH-1:0];
            step_qbit = 1'b0;
        end
        step_quo = {quo_q[WIDTH-2:0], step_qbit};
    end

    // Datapath next values: operand latch, iteration and result capture
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        count_d   = count_q;
        res_quo_d = res_quo_q;
        res_rem_d = res_rem_q;
        divzero_d = divzero_q;
        if (accept_s) begin
            if (i_Op2 == '0) begin
                res_quo_d = '1;
                res_rem_d = i_Op1;
                divzero_d = 1'b1;
            end else begin
                rem_d   = '0;
                quo_d   = i_Op1;
                div_d   = i_Op2;
                count_d = '0;
            end
        end else if ((state_q == S_RUN) && !i_Flush) begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            count_d = count_q + CW'(1);
            if (last_s) begin
                res_quo_d = step_quo;
                res_rem_d = step_rem;
                divzero_d = 1'b0;
            end else begin
                res_quo_d = res_quo_q;
            end
        end else begin
            rem_d = rem_q;
        end
    end

    // Outputs: status flops track the next state, stall is combinational
    always_comb begin
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        o_Stall = accept_s || (state_q == S_RUN);
    end

    assign o_Busy       = busy_q;
    assign o_Done       = done_q;
    assign ro_Quotient  = res_quo_q;
    assign ro_Remainder = res_rem_q;
    assign ro_DivZero   = divzero_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: directed scenarios plus randomized divides
// compared against plain '/' and '%' arithmetic.
module tb_alu_div_seq;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             i_Start;
    logic             i_Flush;
    logic [WIDTH-1:0] i_Op1;
    logic [WIDTH-1:0] i_Op2;
    logic             o_Busy;
    logic             o_Stall;
    logic             o_Done;
    logic [WIDTH-1:0] ro_Quotient;
    logic [WIDTH-1:0] ro_Remainder;
    logic             ro_DivZero;

    int vectors = 0;
    int errors  = 0;

    logic [WIDTH-1:0] q_e, r_e;
    logic             dz_e;
    int               lat;

    alu_div_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_Start      (i_Start),
        .i_Flush      (i_Flush),
        .i_Op1        (i_Op1),
        .i_Op2        (i_Op2),
        .o_Busy       (o_Busy),
        .o_Stall      (o_Stall),
        .o_Done       (o_Done),
        .ro_Quotient  (ro_Quotient),
        .ro_Remainder (ro_Remainder),
        .ro_DivZero   (ro_DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned divide, divisor zero gives all-ones quotient and remainder = dividend
    function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                    output logic dz);
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        i_Op1   = a;
        i_Op2   = b;
        i_Start = 1'b1;
        i_Flush = 1'b0;
        #1;
    endtask

    // Bounded wait for o_Done; lat = cycles after accept, or -1 if the budget expires
    task automatic wait_done(input int budget, output int l);
        l = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            i_Start = 1'b0;
            if (o_Done === 1'b1) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        i_Start = 1'b0;
        i_Flush = 1'b0;
        i_Op1   = '0;
        i_Op2   = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({o_Busy, o_Stall, o_Done, ro_DivZero} !== 4'b0000 || ro_Quotient !== 32'd0 || ro_Remainder !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b stall=%b done=%b dz=%b q=%h r=%h, need all 0",
                     o_Busy, o_Stall, o_Done, ro_DivZero, ro_Quotient, ro_Remainder);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int done_at;
        launch(32'd100, 32'd7);
        vectors++;
        if (o_Stall !== 1'b1) begin
            errors++;
            $display("FAIL basic_stall_accept: got %b need 1", o_Stall);
        end
        done_at = -1;
        for (int k = 1; k <= WIDTH + 3; k++) begin
            @(negedge clk);
            i_Start = 1'b0;
            vectors++;
            if (o_Stall !== (k <= WIDTH) || o_Busy !== (k <= WIDTH + 1)) begin
                errors++;
                $display("FAIL basic_stall_busy: cycle T+%0d stall=%b busy=%b need %b %b",
                         k, o_Stall, o_Busy, (k <= WIDTH), (k <= WIDTH + 1));
            end
            if (o_Done === 1'b1) begin
                if (done_at < 0) done_at = k;
                vectors++;
                if (ro_Quotient !== 32'd14 || ro_Remainder !== 32'd2 || ro_DivZero !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_result: q=%0d r=%0d dz=%b need 14 2 0",
                             ro_Quotient, ro_Remainder, ro_DivZero);
                end
            end
        end
        vectors++;
        if (done_at !== WIDTH + 1) begin
            errors++;
            $display("FAIL basic_latency: done at T+%0d need T+%0d", done_at, WIDTH + 1);
        end
    endtask

    task automatic test_edges();
        logic [WIDTH-1:0] a_tab [2];
        logic [WIDTH-1:0] b_tab [2];
        a_tab[0] = 32'hFFFF_FFFF; b_tab[0] = 32'h0000_0001;
        a_tab[1] = 32'h0000_000A; b_tab[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            ref_div(a_tab[i], b_tab[i], q_e, r_e, dz_e);
            launch(a_tab[i], b_tab[i]);
            wait_done(WIDTH + 5, lat);
            vectors++;
            if (lat !== WIDTH + 1 || ro_Quotient !== q_e || ro_Remainder !== r_e || ro_DivZero !== dz_e) begin
                errors++;
                $display("FAIL edge_%0d: lat=%0d q=%h r=%h dz=%b need lat=%0d q=%h r=%h dz=%b",
                         i, lat, ro_Quotient, ro_Remainder, ro_DivZero, WIDTH + 1, q_e, r_e, dz_e);
            end
        end
    endtask

    task automatic test_div0();
        launch(32'd5, 32'd0);
        vectors++;
        if (o_Stall !== 1'b1) begin
            errors++;
            $display("FAIL div0_stall_accept: got %b need 1", o_Stall);
        end
        @(negedge clk);
        i_Start = 1'b0;
        vectors++;
        if (o_Done !== 1'b1 || o_Stall !== 1'b0 || ro_Quotient !== 32'hFFFF_FFFF ||
            ro_Remainder !== 32'd5 || ro_DivZero !== 1'b1) begin
            errors++;
            $display("FAIL div0_result: done=%b stall=%b q=%h r=%0d dz=%b need 1 0 ffffffff 5 1",
                     o_Done, o_Stall, ro_Quotient, ro_Remainder, ro_DivZero);
        end
        @(negedge clk);
        vectors++;
        if (o_Done !== 1'b0 || o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL div0_after: done=%b busy=%b need 0 0", o_Done, o_Busy);
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        int first;
        launch(32'd1000, 32'd3);
        dones = 0;
        first = -1;
        for (int k = 1; k <= WIDTH + 8; k++) begin
            @(negedge clk);
            if (k == 5) begin
                i_Op1   = 32'd7;
                i_Op2   = 32'd2;
                i_Start = 1'b1;
            end else begin
                i_Start = 1'b0;
            end
            if (o_Done === 1'b1) begin
                dones++;
                if (first < 0) first = k;
            end
        end
        vectors++;
        if (dones !== 1 || first !== WIDTH + 1 || ro_Quotient !== 32'd333 || ro_Remainder !== 32'd1) begin
            errors++;
            $display("FAIL start_in_run: dones=%0d first=%0d q=%0d r=%0d need 1 %0d 333 1",
                     dones, first, ro_Quotient, ro_Remainder, WIDTH + 1);
        end
    endtask

    task automatic test_flush();
        int dones;
        launch(32'd9, 32'd4);
        wait_done(WIDTH + 5, lat);
        vectors++;
        if (lat !== WIDTH + 1 || ro_Quotient !== 32'd2 || ro_Remainder !== 32'd1) begin
            errors++;
            $display("FAIL flush_pre: lat=%0d q=%0d r=%0d need %0d 2 1", lat, ro_Quotient, ro_Remainder, WIDTH + 1);
        end
        launch(32'd50, 32'd5);
        dones = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            i_Start = 1'b0;
            if (k == 10) i_Flush = 1'b1;
            if (o_Done === 1'b1) dones++;
        end
        @(negedge clk);
        i_Flush = 1'b0;
        vectors++;
        if (o_Busy !== 1'b0 || o_Stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy=%b stall=%b need 0 0", o_Busy, o_Stall);
        end
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (o_Done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0 || ro_Quotient !== 32'd2 || ro_Remainder !== 32'd1 || ro_DivZero !== 1'b0) begin
            errors++;
            $display("FAIL flush_retain: dones=%0d q=%0d r=%0d dz=%b need 0 2 1 0",
                     dones, ro_Quotient, ro_Remainder, ro_DivZero);
        end
    endtask

    task automatic test_reset_midrun();
        int dones;
        launch(32'd77, 32'd9);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            i_Start = 1'b0;
            if (k == 20) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({o_Busy, o_Stall, o_Done, ro_DivZero} !== 4'b0000 || ro_Quotient !== 32'd0 || ro_Remainder !== 32'd0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%b stall=%b done=%b dz=%b q=%h r=%h need all 0",
                     o_Busy, o_Stall, o_Done, ro_DivZero, ro_Quotient, ro_Remainder);
        end
        launch(32'd12, 32'd4);
        wait_done(WIDTH + 5, lat);
        vectors++;
        if (lat !== WIDTH + 1 || ro_Quotient !== 32'd3 || ro_Remainder !== 32'd0) begin
            errors++;
            $display("FAIL after_reset: lat=%0d q=%0d r=%0d need %0d 3 0", lat, ro_Quotient, ro_Remainder, WIDTH + 1);
        end
        // Start together with flush in IDLE must not be accepted
        @(negedge clk);
        i_Op1   = 32'd8;
        i_Op2   = 32'd0;
        i_Start = 1'b1;
        i_Flush = 1'b1;
        #1;
        vectors++;
        if (o_Stall !== 1'b0) begin
            errors++;
            $display("FAIL start_flush_stall: got %b need 0", o_Stall);
        end
        dones = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            i_Start = 1'b0;
            i_Flush = 1'b0;
            if (o_Done === 1'b1 || o_Busy === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0 || ro_Quotient !== 32'd3 || ro_DivZero !== 1'b0) begin
            errors++;
            $display("FAIL start_flush_accept: activity=%0d q=%0d dz=%b need 0 3 0", dones, ro_Quotient, ro_DivZero);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom();
            case ($urandom_range(3, 0))
                0:       b = '0;
                1:       b = WIDTH'($urandom_range(15, 1));
                2:       b = a >> $urandom_range(WIDTH - 1, 0);
                default: b = $urandom();
            endcase
            if ($urandom_range(3, 0) == 0) a = WIDTH'($urandom_range(255, 0));
            ref_div(a, b, q_e, r_e, dz_e);
            launch(a, b);
            wait_done(WIDTH + 5, lat);
            vectors++;
            if (lat !== (dz_e ? 1 : WIDTH + 1) || ro_Quotient !== q_e || ro_Remainder !== r_e || ro_DivZero !== dz_e) begin
                errors++;
                $display("FAIL random_%0d: %h/%h lat=%0d q=%h r=%h dz=%b need lat=%0d q=%h r=%h dz=%b",
                         i, a, b, lat, ro_Quotient, ro_Remainder, ro_DivZero,
                         dz_e ? 1 : WIDTH + 1, q_e, r_e, dz_e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a, b;
        int t0, t1;
        t0 = 0;
        for (int i = 0; i < 6; i++) begin
            a = $urandom();
            b = WIDTH'($urandom_range(1000, 1));
            ref_div(a, b, q_e, r_e, dz_e);
            launch(a, b);
            if (i == 1) t0 = $time;
            wait_done(WIDTH + 5, lat);
            if (i == 2) t1 = $time;
            vectors++;
            if (lat !== WIDTH + 1 || ro_Quotient !== q_e || ro_Remainder !== r_e) begin
                errors++;
                $display("FAIL b2b_%0d: lat=%0d q=%h r=%h need %0d %h %h", i, lat, ro_Quotient, ro_Remainder, WIDTH + 1, q_e, r_e);
            end
        end
        // Start of op 1 to done of op 2 spans one full op period plus one latency
        vectors++;
        if ((t1 - t0 + 1) / 10 !== (WIDTH + 2) + (WIDTH + 1)) begin
            errors++;
            $display("FAIL b2b_throughput: span=%0d cycles need %0d", (t1 - t0 + 1) / 10, 2 * WIDTH + 3);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div0();
        test_start_ignored();
        test_flush();
        test_reset_midrun();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
